// File: rtl/brick_pkg.sv
// Shared definitions for the brick playfield: grid geometry, direction bit
// meanings, the game state enum and cell indexing helpers.
package brick_pkg;

  localparam int ROWS  = 12;
  localparam int COLS  = 16;
  localparam int CELLS = ROWS * COLS;

  // Ball direction bit positions: bit1 set moves the ball to row+1,
  // bit0 set moves it to col+1; a cleared bit means -1 on that axis.
  localparam int DIR_ROW_DOWN_BIT = 1;
  localparam int DIR_COL_PLUS_BIT = 0;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WON  = 2'd1,
    ST_LOST = 2'd2
  } state_e;

  // Cell (r,c) lives at bit r*16+c, which is simply the concatenation.
  function automatic logic [7:0] cell_index(input logic [3:0] r, input logic [3:0] c);
    return {r, c};
  endfunction

  // Full-row brick image for rows first..last inclusive.
  function automatic logic [CELLS-1:0] brick_image(input int first, input int last);
    logic [CELLS-1:0] img;
    img = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (r >= first && r <= last) img[r*COLS +: COLS] = '1;
    end
    return img;
  endfunction

endpackage

// File: rtl/brick_field_hit_detect.sv
// Combinational bounce analysis: finds which neighbouring bricks the ball
// bounces off this cycle and reports them as erase masks plus a count.
module brick_hit_detect
  import brick_pkg::*;
(
  input  logic [CELLS-1:0] bricks_i,
  input  logic [CELLS-1:0] paddle_i,
  input  logic [3:0]       ball_row_i,
  input  logic [3:0]       ball_col_i,
  input  logic [1:0]       ball_dir_i,
  output logic [CELLS-1:0] erase_v_o,
  output logic [CELLS-1:0] erase_h_o,
  output logic [CELLS-1:0] erase_d_o,
  output logic [1:0]       count_o
);

  logic [4:0] nextRow;
  logic [4:0] nextCol;
  logic       rowOk;
  logic       vIn;
  logic       hIn;
  logic       dIn;
  logic [7:0] vIdx;
  logic [7:0] hIdx;
  logic [7:0] dIdx;
  logic       vBrick;
  logic       hBrick;
  logic       dBrick;
  logic       vSolid;
  logic       hSolid;
  logic       takeV;
  logic       takeH;
  logic       takeD;

  // Neighbour lookup; off-grid cells count as solid walls but never as bricks,
  // and the diagonal is only hit when both side neighbours are open.
  always_comb begin
    nextRow = ball_dir_i[DIR_ROW_DOWN_BIT] ? ({1'b0, ball_row_i} + 5'd1)
                                           : ({1'b0, ball_row_i} - 5'd1);
    nextCol = ball_dir_i[DIR_COL_PLUS_BIT] ? ({1'b0, ball_col_i} + 5'd1)
                                           : ({1'b0, ball_col_i} - 5'd1);
    rowOk = ball_row_i < 4'(ROWS);
    vIn   = nextRow < 5'(ROWS);
    hIn   = rowOk && (nextCol < 5'(COLS));
    dIn   = vIn && (nextCol < 5'(COLS));

    vIdx = vIn ? cell_index(nextRow[3:0], ball_col_i) : 8'd0;
    hIdx = hIn ? cell_index(ball_row_i, nextCol[3:0]) : 8'd0;
    dIdx = dIn ? cell_index(nextRow[3:0], nextCol[3:0]) : 8'd0;

    vBrick = vIn && bricks_i[vIdx];
    hBrick = hIn && bricks_i[hIdx];
    dBrick = dIn && bricks_i[dIdx];
    vSolid = !vIn || bricks_i[vIdx] || paddle_i[vIdx];
    hSolid = !hIn || bricks_i[hIdx] || paddle_i[hIdx];

    takeV = vBrick;
    takeH = hBrick;
    takeD = !(vBrick || hBrick) && dBrick && !vSolid && !hSolid;

    erase_v_o = takeV ? (CELLS'(1) << vIdx) : '0;
    erase_h_o = takeH ? (CELLS'(1) << hIdx) : '0;
    erase_d_o = takeD ? (CELLS'(1) << dIdx) : '0;
    count_o   = {1'b0, takeV} + {1'b0, takeH} + {1'b0, takeD};
  end

endmodule

// File: rtl/brick_field.sv
// Playfield owner: brick storage, paddle overlay, score/brick counters and
// the PLAY/WON/LOST game state that drive the ball stage.
module brick_field
  import brick_pkg::*;
#(
  parameter int BRICK_ROW_FIRST = 1,
  parameter int BRICK_ROW_LAST  = 3,
  parameter int PADDLE_ROW      = 10,
  parameter int PADDLE_W        = 4,
  parameter int LOSE_ROW        = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart_i,
  input  logic [3:0]       paddle_col_i,
  input  logic [3:0]       ball_row_i,
  input  logic [3:0]       ball_col_i,
  input  logic [1:0]       ball_dir_i,
  output logic [CELLS-1:0] data_o,
  output logic [7:0]       score_o,
  output logic [7:0]       bricks_left_o,
  output logic             hit_o,
  output logic             game_won_o,
  output logic             game_lost_o
);

  localparam logic [CELLS-1:0] RESET_IMAGE = brick_image(BRICK_ROW_FIRST, BRICK_ROW_LAST);
  localparam logic [7:0]       RESET_COUNT = 8'((BRICK_ROW_LAST - BRICK_ROW_FIRST + 1) * COLS);

  logic [CELLS-1:0] bricks_q;
  logic [CELLS-1:0] bricks_d;
  logic [7:0]       score_q;
  logic [7:0]       score_d;
  logic [7:0]       left_q;
  logic [7:0]       left_d;
  logic             hit_q;
  logic             hit_d;
  state_e           state_q;

  logic [CELLS-1:0] paddleMask;
  logic [CELLS-1:0] eraseV;
  logic [CELLS-1:0] eraseH;
  logic [CELLS-1:0] eraseD;
  logic [1:0]       eraseCount;
  logic [8:0]       scoreSum;
  logic             wonNow;
  logic             lostNow;

  // Paddle overlay cells, clipped at the right edge of the grid.
  always_comb begin
    paddleMask = '0;
    for (int c = 0; c < COLS; c++) begin
      if (5'(c) >= {1'b0, paddle_col_i} &&
          5'(c) <= ({1'b0, paddle_col_i} + 5'(PADDLE_W - 1)))
        paddleMask[cell_index(4'(PADDLE_ROW), 4'(c))] = 1'b1;
    end
  end

  brick_hit_detect u_hit_detect (
    .bricks_i   (bricks_q),
    .paddle_i   (paddleMask),
    .ball_row_i (ball_row_i),
    .ball_col_i (ball_col_i),
    .ball_dir_i (ball_dir_i),
    .erase_v_o  (eraseV),
    .erase_h_o  (eraseH),
    .erase_d_o  (eraseD),
    .count_o    (eraseCount)
  );

  // Next brick image and counters if the game is in play this cycle.
  always_comb begin
    bricks_d = bricks_q & ~(eraseV | eraseH | eraseD);
    scoreSum = {1'b0, score_q} + 9'(eraseCount);
    score_d  = scoreSum[8] ? 8'hFF : scoreSum[7:0];
    left_d   = (left_q >= 8'(eraseCount)) ? (left_q - 8'(eraseCount)) : 8'd0;
    hit_d    = eraseCount != 2'd0;
    wonNow   = left_d == 8'd0;
    lostNow  = ball_row_i == 4'(LOSE_ROW);
  end

  // Game state machine and playfield registers; restart beats everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bricks_q <= RESET_IMAGE;
      score_q  <= 8'd0;
      left_q   <= RESET_COUNT;
      hit_q    <= 1'b0;
      state_q  <= ST_PLAY;
    end else if (restart_i) begin
      bricks_q <= RESET_IMAGE;
      score_q  <= 8'd0;
      left_q   <= RESET_COUNT;
      hit_q    <= 1'b0;
      state_q  <= ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          bricks_q <= bricks_d;
          score_q  <= score_d;
          left_q   <= left_d;
          hit_q    <= hit_d;
          if (wonNow)       state_q <= ST_WON;
          else if (lostNow) state_q <= ST_LOST;
        end
        default: hit_q <= 1'b0;
      endcase
    end
  end

  assign data_o        = (state_q == ST_PLAY) ? (bricks_q | paddleMask) : '1;
  assign score_o       = score_q;
  assign bricks_left_o = left_q;
  assign hit_o         = hit_q;
  assign game_won_o    = state_q == ST_WON;
  assign game_lost_o   = state_q == ST_LOST;

endmodule
